// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: in-order prediction queue, BTB updates and mispredict redirect/flush; `BRU_STATS_EN adds stat counters
module branch_resolution_unit #(
  parameter int BRU_DEPTH = 4,
  parameter int BRU_CNT_W = $clog2(BRU_DEPTH) + 1
) (
  input  logic                 bru_clk,
  input  logic                 bru_reset,
  input  logic                 bru_fetch_valid,
  input  logic [31:0]          bru_fetch_pc,
  input  logic                 bru_fetch_pred_taken,
  input  logic [31:0]          bru_fetch_pred_target,
  output logic                 bru_fetch_ready,
  input  logic                 bru_resolve_valid,
  input  logic                 bru_resolve_taken,
  input  logic [31:0]          bru_resolve_target,
  output logic                 bru_redirect,
  output logic [31:0]          bru_redirect_pc,
  output logic                 bru_btb_write,
  output logic                 bru_btb_branch_taken,
  output logic [31:0]          bru_btb_new_pc,
  output logic [31:0]          bru_btb_data,
  output logic [BRU_CNT_W-1:0] bru_count,
  output logic                 bru_error
`ifdef BRU_STATS_EN
  ,output logic [31:0]         bru_stat_branches,
  output logic [31:0]          bru_stat_mispredicts
`endif
);
  localparam int PW = $clog2(BRU_DEPTH);
  localparam logic [PW-1:0] ptr_one = 1;
  logic [31:0] q_pc [BRU_DEPTH];
  logic [31:0] q_target [BRU_DEPTH];
  logic q_taken [BRU_DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop, mis;
  logic [31:0] e_pc, e_target;
  logic e_taken;
  always_comb begin
    bru_fetch_ready = !bru_reset && bru_count < BRU_CNT_W'(BRU_DEPTH);
    push = bru_fetch_valid && bru_fetch_ready;
    pop = bru_resolve_valid && bru_count != '0;
    e_pc = q_pc[head];
    e_target = q_target[head];
    e_taken = q_taken[head];
    mis = pop && (e_taken != bru_resolve_taken || (e_taken && bru_resolve_taken && e_target != bru_resolve_target));
  end
  always_ff @(posedge bru_clk) begin
    if (bru_reset) begin
      head <= '0;
      tail <= '0;
      bru_count <= '0;
      bru_error <= 1'b0;
      bru_redirect <= 1'b0;
      bru_redirect_pc <= '0;
      bru_btb_write <= 1'b0;
      bru_btb_branch_taken <= 1'b0;
      bru_btb_new_pc <= '0;
      bru_btb_data <= '0;
    end else begin
      bru_btb_write <= pop;
      bru_btb_branch_taken <= pop && bru_resolve_taken;
      bru_btb_new_pc <= pop ? e_pc : '0;
      bru_btb_data <= pop ? bru_resolve_target : '0;
      bru_redirect <= mis;
      bru_redirect_pc <= !mis ? '0 : bru_resolve_taken ? bru_resolve_target : e_pc + 32'd4;
      bru_error <= bru_error || (bru_resolve_valid && bru_count == '0);
      if (mis) begin
        head <= '0;
        tail <= '0;
        bru_count <= '0;
      end else begin
        if (push) begin
          q_pc[tail] <= bru_fetch_pc;
          q_target[tail] <= bru_fetch_pred_target;
          q_taken[tail] <= bru_fetch_pred_taken;
          tail <= tail + ptr_one;
        end
        if (pop) head <= head + ptr_one;
        bru_count <= bru_count + BRU_CNT_W'(push) - BRU_CNT_W'(pop);
      end
    end
  end
`ifdef BRU_STATS_EN
  always_ff @(posedge bru_clk) begin
    if (bru_reset) begin
      bru_stat_branches <= '0;
      bru_stat_mispredicts <= '0;
    end else begin
      if (pop && bru_stat_branches != '1) bru_stat_branches <= bru_stat_branches + 32'd1;
      if (mis && bru_stat_mispredicts != '1) bru_stat_mispredicts <= bru_stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit: directed vector table plus randomized run against a queue-based reference model
module tb_branch_resolution_unit;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;
  logic clk = 0, rst = 1;
  logic fv = 0, pt = 0, rv = 0, rt = 0;
  logic [31:0] pc = 0, ptg = 0, rtg = 0;
  logic ready, redirect, btb_write, btb_taken, error;
  logic [31:0] redirect_pc, btb_new_pc, btb_data;
  logic [CW-1:0] count;
  int checks = 0, failures = 0;
  branch_resolution_unit #(.BRU_DEPTH(D)) dut (
    .bru_clk(clk), .bru_reset(rst),
    .bru_fetch_valid(fv), .bru_fetch_pc(pc), .bru_fetch_pred_taken(pt), .bru_fetch_pred_target(ptg),
    .bru_fetch_ready(ready),
    .bru_resolve_valid(rv), .bru_resolve_taken(rt), .bru_resolve_target(rtg),
    .bru_redirect(redirect), .bru_redirect_pc(redirect_pc),
    .bru_btb_write(btb_write), .bru_btb_branch_taken(btb_taken), .bru_btb_new_pc(btb_new_pc), .bru_btb_data(btb_data),
    .bru_count(count), .bru_error(error)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic fv; logic [31:0] pc; logic pt; logic [31:0] ptg;
    logic rv; logic rt; logic [31:0] rtg;
    logic ew; logic er; logic [31:0] erpc; logic [31:0] epc; int ecnt; logic eerr;
  } vec_t;
  typedef struct { logic [31:0] pc; logic t; logic [31:0] tg; } ent_t;
  ent_t mq[$];
  logic merr = 0, mw, mr, mt;
  logic [31:0] mrpc, mnpc, mdata;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic [31:0] p, input logic ft, input logic [31:0] fg,
                      input logic v, input logic t, input logic [31:0] g);
    logic push, mis;
    ent_t e;
    rst = r; fv = f; pc = p; pt = ft; ptg = fg; rv = v; rt = t; rtg = g;
    #1;
    chk("fetch_ready", 32'(ready), 32'(!r && mq.size() < D));
    push = !r && f && mq.size() < D;
    mis = 0;
    {mw, mr, mt, mrpc, mnpc, mdata} = '0;
    if (r) begin
      mq.delete();
      merr = 0;
    end else begin
      if (v && mq.size() == 0) merr = 1;
      else if (v) begin
        e = mq.pop_front();
        mis = (e.t != t) || (e.t && t && e.tg != g);
        mw = 1; mt = t; mnpc = e.pc; mdata = g; mr = mis;
        if (mis) mrpc = t ? g : e.pc + 32'd4;
      end
      if (mis) mq.delete();
      else if (push) mq.push_back('{p, ft, fg});
    end
    @(posedge clk);
    #1;
    chk("btb_write", 32'(btb_write), 32'(mw));
    chk("redirect", 32'(redirect), 32'(mr));
    chk("redirect_pc", redirect_pc, mrpc);
    chk("count", 32'(count), 32'(mq.size()));
    chk("error", 32'(error), 32'(merr));
    if (mw) begin
      chk("btb_taken", 32'(btb_taken), 32'(mt));
      chk("btb_new_pc", btb_new_pc, mnpc);
      chk("btb_data", btb_data, mdata);
    end
  endtask
  function automatic vec_t mk(logic f, logic [31:0] p, logic ft, logic [31:0] fg, logic v, logic t, logic [31:0] g,
                              logic ew, logic er, logic [31:0] erpc, logic [31:0] epc, int ecnt, logic eerr);
    mk = '{f, p, ft, fg, v, t, g, ew, er, erpc, epc, ecnt, eerr};
  endfunction
  initial begin
    tbl.push_back(mk(1, 'h100, 1, 'h200, 0, 0, 0,      0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h200,          1, 0, 0, 'h100, 0, 0));
    tbl.push_back(mk(1, 'h104, 0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h300,          1, 1, 'h300, 'h104, 0, 0));
    tbl.push_back(mk(1, 'h10, 1, 'h1000, 0, 0, 0,      0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 'h20, 1, 'h2000, 0, 0, 0,      0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 'h30, 1, 'h3000, 0, 0, 0,      0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 'h40, 1, 'h4000, 0, 0, 0,      0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 'h50, 1, 'h5000, 0, 0, 0,      0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h1000,         1, 0, 0, 'h10, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h2000,         1, 0, 0, 'h20, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h3000,         1, 0, 0, 'h30, 1, 0));
    tbl.push_back(mk(1, 'h60, 1, 'h6000, 0, 0, 0,      0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 'h70, 1, 'h7000, 0, 0, 0,      0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 'h80, 1, 'h8000, 1, 0, 'h999,  1, 1, 'h44, 'h40, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h90, 0, 0, 1, 0, 0,           0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,              1, 0, 0, 'h90, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_outs", {26'b0, redirect, btb_write, btb_taken, error, 2'b0}, 0);
    chk("rst_data", redirect_pc | btb_new_pc | btb_data, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", 32'(ready), 1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].fv, tbl[i].pc, tbl[i].pt, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
      chk($sformatf("v%0d_write", i), 32'(btb_write), 32'(tbl[i].ew));
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(tbl[i].er));
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].erpc);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].eerr));
      if (tbl[i].ew) chk($sformatf("v%0d_new_pc", i), btb_new_pc, tbl[i].epc);
    end
    step(1, 1, 'h200, 1, 'h200, 1, 1, 'h200);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 255)) << 2,
           1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 32'h200 : 32'h300,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 32'h200 : 32'h300);
    step(1, 1, 'h40, 1, 'h200, 1, 0, 'h300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-side writer for the branch target buffer. Queues each fetch-stage prediction in program order and matches it against the branch outcome from execute.
- Per resolved branch: issues a one-cycle BTB update (write, taken, pc, target). On a wrong prediction, also raises a redirect with the correct next PC and flushes younger in-flight predictions.

Parameters:
- BRU_DEPTH, 4, in-flight prediction queue entries; power of two, >=2
- BRU_CNT_W, $clog2(BRU_DEPTH)+1, width of occupancy count

Ports:
- bru_clk  input  1  clock, all state on rising edge
- bru_reset  input  1  synchronous, active-high reset
- bru_fetch_valid  input  1  fetch presents a branch prediction record
- bru_fetch_pc  input  32  PC of predicted branch
- bru_fetch_pred_taken  input  1  BTB valid prediction (1 = predicted taken)
- bru_fetch_pred_target  input  32  BTB target used by fetch
- bru_fetch_ready  output  1  queue can accept a record
- bru_resolve_valid  input  1  execute resolves oldest branch
- bru_resolve_taken  input  1  actual direction
- bru_resolve_target  input  32  computed branch target (always supplied)
- bru_redirect  output  1  one-cycle mispredict pulse
- bru_redirect_pc  output  32  correct next PC
- bru_btb_write  output  1  one-cycle BTB update pulse
- bru_btb_branch_taken  output  1  actual direction to BTB
- bru_btb_new_pc  output  32  branch PC to BTB
- bru_btb_data  output  32  target to BTB
- bru_count  output  BRU_CNT_W  current queue occupancy
- bru_error  output  1  sticky: resolve arrived with empty queue

Behaviour:
- Reset (bru_reset high at edge): queue emptied, count 0, all registered outputs 0, error cleared. bru_fetch_ready is 0 while bru_reset is high.
- Push: fetch_valid && fetch_ready. Record {pc, pred_taken, pred_target} written at tail. fetch_ready = (count < BRU_DEPTH), based on the registered count. When full, fetch_ready stays 0 even if a pop occurs in the same cycle.
- Pop: resolve_valid && count != 0, oldest entry. Head/tail pointers wrap modulo BRU_DEPTH.
- Mispredict: (pred_taken != resolve_taken) OR (pred_taken && resolve_taken && pred_target != resolve_target).
- Correct PC: resolve_target if resolve_taken, else entry pc + 4 (32-bit wrap).
- Outputs are registered, 1-cycle latency from the resolve cycle. Next cycle: btb_write=1, btb_branch_taken=resolve_taken, btb_new_pc=entry pc, btb_data=resolve_target. redirect=mispredict, redirect_pc=correct PC when mispredict, else 0.
- Every pulse output returns to 0 the following cycle unless a new resolve occurs.
- Mispredict flush: on the pop edge the whole queue is cleared (count 0, head=tail). Any push in that same cycle is dropped as wrong-path.
- Simultaneous push and pop without mispredict: count unchanged, both take effect.
- Resolve with count 0: no BTB write, no redirect, error set sticky until reset. A same-cycle push is still accepted but is not matched.
- Reset asserted mid-operation overrides push, pop and flush.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined: adds outputs bru_stat_branches (32) and bru_stat_mispredicts (32). Both are saturating counters, incremented on each valid pop / each mispredict, and cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset -> all outputs 0, count 0; cycle after release, fetch_ready=1.
- Push pc 0x100, pred_taken 1, target 0x200; resolve taken, 0x200 -> next cycle btb_write=1, taken=1, new_pc=0x100, data=0x200, redirect=0, count=0.
- Push pc 0x104, pred_taken 0; resolve taken, target 0x300 -> redirect=1, redirect_pc=0x300, btb_write=1, taken=1, data=0x300.
- Push 4 records (0x10,0x20,0x30,0x40) -> fetch_ready=0 and a 5th push is ignored. Then resolve 0x10 correctly -> count 3, fetch_ready=1, and the next pop returns 0x20.
- Queue holds 3, oldest pc 0x40 predicted taken; resolve not-taken with a same-cycle push -> redirect_pc=0x44, count=0, pushed record dropped.
- Resolve on empty queue -> error=1, btb_write=0, redirect=0; error holds until reset.
